ysyx_22040750_ifu: RTL and testbench

YSYX_22040750_IFU -- requirements
Module: ysyx_22040750_ifu

---
 rtl/ysyx_22040750_ifu.sv | 128 ++++++++++++
 tb/tb_ysyx_22040750_ifu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040750_ifu.sv
// Instruction fetch unit: one outstanding imem request, IF/ID register, flush with drain of stale responses.
// Optional misaligned-PC trap fetch is enabled by defining YSYX_22040750_IFU_MISALIGN_EN.
module ysyx_22040750_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_pc_valid,
  output logic        O_pc_ready,
  input  logic [31:0] I_dnpc,
  input  logic        I_flush,
  input  logic [31:0] I_flush_pc,
  output logic        O_imem_req_valid,
  output logic [31:0] O_imem_addr,
  input  logic        I_imem_req_ready,
  input  logic        I_imem_rsp_valid,
  input  logic [31:0] I_imem_rsp_data,
  output logic        O_IF_ID_valid,
  output logic [31:0] O_IF_ID_pc,
  output logic [31:0] O_IF_ID_snpc,
  output logic [31:0] O_IF_ID_inst,
  output logic        O_IF_ID_misalign,
  input  logic        I_IF_ID_ready
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
`ifdef YSYX_22040750_IFU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_OUT, S_NPC, S_DRAIN} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            misaligned, misaligned_nxt;
  logic            load, clr_valid, load_mis, drain;
  logic [XLEN-1:0] load_inst;

  assign misaligned     = MIS_EN && (pc[1:0] != 2'b00);
  assign misaligned_nxt = MIS_EN && (pc_nxt[1:0] != 2'b00);
  assign O_imem_addr    = pc;

  // A flush must wait out any request the memory still owes us
  assign drain = ((state == S_WAIT || state == S_DRAIN) && !I_imem_rsp_valid) ||
                 (state == S_REQ && !misaligned && I_imem_req_ready);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load      = 1'b0;
    load_inst = I_imem_rsp_data;
    load_mis  = 1'b0;
    clr_valid = 1'b0;
    case (state)
      S_REQ: begin
        if (misaligned) begin
          load      = 1'b1;
          load_inst = NOP_INST;
          load_mis  = 1'b1;
          state_nxt = S_OUT;
        end else if (I_imem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (I_imem_rsp_valid) begin
          load      = 1'b1;
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (I_IF_ID_ready) begin
          clr_valid = 1'b1;
          state_nxt = S_NPC;
        end
      end
      S_NPC: begin
        if (I_pc_valid) begin
          pc_nxt    = I_dnpc;
          state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        if (I_imem_rsp_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
    if (I_flush) begin
      pc_nxt    = I_flush_pc;
      load      = 1'b0;
      load_mis  = 1'b0;
      clr_valid = 1'b1;
      state_nxt = drain ? S_DRAIN : S_REQ;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state            <= S_REQ;
      pc               <= RESET_PC;
      O_imem_req_valid <= !(MIS_EN && (RESET_PC[1:0] != 2'b00));
      O_pc_ready       <= 1'b0;
      O_IF_ID_valid    <= 1'b0;
      O_IF_ID_pc       <= '0;
      O_IF_ID_snpc     <= '0;
      O_IF_ID_inst     <= '0;
      O_IF_ID_misalign <= 1'b0;
    end else begin
      state            <= state_nxt;
      pc               <= pc_nxt;
      O_imem_req_valid <= (state_nxt == S_REQ) && !misaligned_nxt;
      O_pc_ready       <= (state_nxt == S_NPC);
      if (load) begin
        O_IF_ID_valid    <= 1'b1;
        O_IF_ID_pc       <= pc;
        O_IF_ID_snpc     <= pc + XLEN'(4);
        O_IF_ID_inst     <= load_inst;
        O_IF_ID_misalign <= load_mis;
      end else if (clr_valid) begin
        O_IF_ID_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_ifu.sv
// Randomized self-checking bench for ysyx_22040750_ifu against a transaction-level fetch model.
module tb_ysyx_22040750_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef YSYX_22040750_IFU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        I_clk = 1'b0;
  logic        I_rst, I_pc_valid, I_flush, I_imem_req_ready, I_imem_rsp_valid, I_IF_ID_ready;
  logic [31:0] I_dnpc, I_flush_pc, I_imem_rsp_data;
  logic        O_pc_ready, O_imem_req_valid, O_IF_ID_valid, O_IF_ID_misalign;
  logic [31:0] O_imem_addr, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst;

  ysyx_22040750_ifu #(.RESET_PC(RESET_PC)) dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_pc_valid(I_pc_valid), .O_pc_ready(O_pc_ready), .I_dnpc(I_dnpc),
    .I_flush(I_flush), .I_flush_pc(I_flush_pc),
    .O_imem_req_valid(O_imem_req_valid), .O_imem_addr(O_imem_addr),
    .I_imem_req_ready(I_imem_req_ready),
    .I_imem_rsp_valid(I_imem_rsp_valid), .I_imem_rsp_data(I_imem_rsp_data),
    .O_IF_ID_valid(O_IF_ID_valid), .O_IF_ID_pc(O_IF_ID_pc), .O_IF_ID_snpc(O_IF_ID_snpc),
    .O_IF_ID_inst(O_IF_ID_inst), .O_IF_ID_misalign(O_IF_ID_misalign),
    .I_IF_ID_ready(I_IF_ID_ready)
  );

  always #5 I_clk = ~I_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_fetch  = 0;

  // Reference model: what fetch is wanted, what is owed by memory, what IF/ID must show
  bit          model_on = 1'b0;
  logic [31:0] m_pc;
  bit          m_need, m_live, m_await, m_valid, m_if_mis;
  logic [31:0] m_live_addr, m_if_pc, m_if_snpc, m_if_inst;
  bit          mem_pend = 1'b0;
  logic [31:0] mem_addr;
  int          mem_cnt = 0;
  int          mem_lat_fix = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0093;
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with inputs set; checks this cycle, advances the model over the next edge
  task automatic tick();
    bit acc, rsp, old_pend, exp_req;
    I_imem_rsp_valid = mem_pend && (mem_cnt == 0);
    I_imem_rsp_data  = I_imem_rsp_valid ? mem_word(mem_addr) : 32'hdead_beef;
    if (model_on) begin
      exp_req = m_need && !mem_pend && !(MIS_EN && (m_pc[1:0] != 2'b00));
      check("req_valid", 32'(O_imem_req_valid), 32'(exp_req));
      if (exp_req) check("imem_addr", O_imem_addr, m_pc);
      check("pc_ready", 32'(O_pc_ready), 32'(m_await));
      check("ifid_valid", 32'(O_IF_ID_valid), 32'(m_valid));
      if (m_valid) begin
        check("ifid_pc", O_IF_ID_pc, m_if_pc);
        check("ifid_snpc", O_IF_ID_snpc, m_if_snpc);
        check("ifid_inst", O_IF_ID_inst, m_if_inst);
        check("ifid_misalign", 32'(O_IF_ID_misalign), 32'(m_if_mis));
      end
    end
    if (I_rst) begin
      model_on = 1'b1;
      m_pc = RESET_PC; m_need = 1'b1; m_live = 1'b0; m_await = 1'b0; m_valid = 1'b0;
      m_if_pc = '0; m_if_snpc = '0; m_if_inst = '0; m_if_mis = 1'b0;
      mem_pend = 1'b0;
    end else if (model_on) begin
      acc = O_imem_req_valid && I_imem_req_ready;
      rsp = I_imem_rsp_valid;
      old_pend = mem_pend;
      if (rsp) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (acc) begin
        check("one_outstanding", 32'(mem_pend), 32'd0);
        mem_pend = 1'b1;
        mem_addr = O_imem_addr;
        mem_cnt  = ((mem_lat_fix != 0) ? mem_lat_fix : int'($urandom_range(1, 4))) - 1;
      end
      if (I_flush) begin
        m_pc = I_flush_pc; m_need = 1'b1; m_live = 1'b0; m_await = 1'b0; m_valid = 1'b0;
      end else if (m_await && I_pc_valid) begin
        m_pc = I_dnpc; m_need = 1'b1; m_await = 1'b0;
      end else if (m_valid && I_IF_ID_ready) begin
        m_valid = 1'b0; m_await = 1'b1; n_fetch++;
      end else if (m_live && rsp) begin
        m_valid = 1'b1; m_live = 1'b0; m_if_mis = 1'b0;
        m_if_pc = m_live_addr; m_if_snpc = m_live_addr + 32'd4; m_if_inst = mem_word(m_live_addr);
      end else if (acc) begin
        m_live = 1'b1; m_live_addr = O_imem_addr; m_need = 1'b0;
      end else if (MIS_EN && m_need && !old_pend && (m_pc[1:0] != 2'b00)) begin
        m_valid = 1'b1; m_need = 1'b0; m_if_mis = 1'b1;
        m_if_pc = m_pc; m_if_snpc = m_pc + 32'd4; m_if_inst = 32'h0000_0013;
      end
    end
    @(posedge I_clk);
    @(negedge I_clk);
  endtask

  task automatic fetch_and_consume();
    I_imem_req_ready = 1'b1; mem_lat_fix = 1; tick();
    I_imem_req_ready = 1'b0; tick();
    I_IF_ID_ready = 1'b1; tick();
    I_IF_ID_ready = 1'b0;
  endtask

  initial begin
    I_rst = 1'b1; I_pc_valid = 1'b0; I_flush = 1'b0; I_imem_req_ready = 1'b0;
    I_imem_rsp_valid = 1'b0; I_IF_ID_ready = 1'b0;
    I_dnpc = '0; I_flush_pc = '0; I_imem_rsp_data = '0;
    @(negedge I_clk);
    tick();
    I_rst = 1'b0;

    // Reset state
    check("rst_req_valid", 32'(O_imem_req_valid), 32'd1);
    check("rst_addr", O_imem_addr, 32'h8000_0000);
    check("rst_valid", 32'(O_IF_ID_valid), 32'd0);
    check("rst_pc", O_IF_ID_pc, 32'd0);
    check("rst_snpc", O_IF_ID_snpc, 32'd0);
    check("rst_inst", O_IF_ID_inst, 32'd0);
    check("rst_misalign", 32'(O_IF_ID_misalign), 32'd0);
    check("rst_pc_ready", 32'(O_pc_ready), 32'd0);

    // First fetch with one-cycle memory
    I_imem_req_ready = 1'b1; mem_lat_fix = 1; tick();
    I_imem_req_ready = 1'b0; tick();
    check("first_valid", 32'(O_IF_ID_valid), 32'd1);
    check("first_pc", O_IF_ID_pc, 32'h8000_0000);
    check("first_snpc", O_IF_ID_snpc, 32'h8000_0004);
    check("first_inst", O_IF_ID_inst, 32'h0000_0093);

    // Decode stall, then redirect via dnpc
    repeat (5) tick();
    check("stall_pc_ready", 32'(O_pc_ready), 32'd0);
    check("stall_inst", O_IF_ID_inst, 32'h0000_0093);
    I_IF_ID_ready = 1'b1; tick();
    I_IF_ID_ready = 1'b0;
    check("npc_pc_ready", 32'(O_pc_ready), 32'd1);
    I_pc_valid = 1'b1; I_dnpc = 32'h8000_0100; tick();
    I_pc_valid = 1'b0;
    check("dnpc_req", 32'(O_imem_req_valid), 32'd1);
    check("dnpc_addr", O_imem_addr, 32'h8000_0100);

    // Flush in WAIT, stale response three cycles later
    I_imem_req_ready = 1'b1; mem_lat_fix = 4; tick();
    I_imem_req_ready = 1'b0;
    I_flush = 1'b1; I_flush_pc = 32'h8000_0200; tick();
    I_flush = 1'b0;
    tick();
    check("drain_no_req", 32'(O_imem_req_valid), 32'd0);
    tick();
    tick();
    check("drain_done_req", 32'(O_imem_req_valid), 32'd1);
    check("drain_done_addr", O_imem_addr, 32'h8000_0200);
    check("drain_no_valid", 32'(O_IF_ID_valid), 32'd0);

    // Flush coincident with response
    I_imem_req_ready = 1'b1; mem_lat_fix = 1; tick();
    I_imem_req_ready = 1'b0;
    I_flush = 1'b1; I_flush_pc = 32'h8000_0300; tick();
    I_flush = 1'b0;
    check("coinc_no_valid", 32'(O_IF_ID_valid), 32'd0);
    check("coinc_req", 32'(O_imem_req_valid), 32'd1);
    check("coinc_addr", O_imem_addr, 32'h8000_0300);

    // snpc wraparound
    I_flush = 1'b1; I_flush_pc = 32'hFFFF_FFFC; tick();
    I_flush = 1'b0;
    I_imem_req_ready = 1'b1; mem_lat_fix = 1; tick();
    I_imem_req_ready = 1'b0; tick();
    check("wrap_pc", O_IF_ID_pc, 32'hFFFF_FFFC);
    check("wrap_snpc", O_IF_ID_snpc, 32'h0000_0000);
    I_IF_ID_ready = 1'b1; tick();
    I_IF_ID_ready = 1'b0;

    // Misaligned dnpc
    I_pc_valid = 1'b1; I_dnpc = 32'h8000_0002; tick();
    I_pc_valid = 1'b0;
`ifdef YSYX_22040750_IFU_MISALIGN_EN
    check("mis_no_req", 32'(O_imem_req_valid), 32'd0);
    tick();
    check("mis_valid", 32'(O_IF_ID_valid), 32'd1);
    check("mis_inst", O_IF_ID_inst, 32'h0000_0013);
    check("mis_flag", 32'(O_IF_ID_misalign), 32'd1);
`else
    check("mis_req", 32'(O_imem_req_valid), 32'd1);
    check("mis_addr", O_imem_addr, 32'h8000_0002);
    fetch_and_consume();
`endif

    // Randomized traffic against the model
    I_rst = 1'b1; tick();
    I_rst = 1'b0;
    mem_lat_fix = 0;
    n_fetch = 0;
    for (int i = 0; i < 4000; i++) begin
      I_rst            = ($urandom_range(0, 399) == 0);
      I_flush          = ($urandom_range(0, 19) == 0);
      I_flush_pc       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      I_pc_valid       = $urandom_range(0, 1) == 1;
      I_dnpc           = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      I_imem_req_ready = $urandom_range(0, 1) == 1;
      I_IF_ID_ready    = $urandom_range(0, 1) == 1;
      tick();
    end
    check("random_progress", 32'(n_fetch > 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
